// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT resonant-frequency sequencer:
// FSM state encodings, ADC/frequency constants and the amplitude fold.
package swipt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_SWEEP   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_MEASURE = 3'd4,
        ST_TRACK   = 3'd5,
        ST_FAULT   = 3'd6
    } swipt_state_e;

    localparam logic [11:0] ADC_MID      = 12'h800;
    localparam logic [19:0] DEFAULT_FREQ = 20'h88B8;
    localparam logic [23:0] CYC_2MS      = 24'h30D40;

    // Offset-binary sample to unsigned distance from midscale (11 bits).
    function automatic logic [10:0] amp_fold(input logic [11:0] adc);
        if (adc < ADC_MID) begin
            return 11'h7FF - adc[10:0];
        end
        return adc[10:0];
    endfunction

endpackage

// File: rtl/swipt_amp_peak.sv
// Amplitude fold plus a running-maximum tracker over a window of
// MEAS_CYC valid samples. The folded amplitude is also exported raw so
// the tracking logic can compare live samples against the reference.
module swipt_amp_peak
    import swipt_pkg::*;
#(
    parameter logic [15:0] MEAS_CYC = 16'h1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [11:0] adc,
    input  logic        adc_valid,
    output logic [10:0] amp,
    output logic [10:0] peak,
    output logic        done
);

    logic [10:0] peak_q, peak_d;
    logic [15:0] cnt_q, cnt_d;

    assign amp  = amp_fold(adc);
    assign peak = peak_q;
    assign done = (cnt_q == 16'd0);

    // Clear arms a new window; while enabled, each valid sample updates the max and counts down.
    always_comb begin
        peak_d = peak_q;
        cnt_d  = cnt_q;
        if (clr) begin
            peak_d = '0;
            cnt_d  = MEAS_CYC;
        end else if (en && adc_valid && !done) begin
            if (amp > peak_q) begin
                peak_d = amp;
            end
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Window state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
            cnt_q  <= '0;
        end else begin
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/swipt_freq_sequencer.sv
// Top-level SWIPT frequency-search controller. Runs the sweep engine via
// its go/done handshake, applies the reported best frequency, measures a
// reference amplitude there, then tracks and re-sweeps on a large drop.
module swipt_freq_sequencer #(
    parameter logic [23:0] STARTUP_CYC       = swipt_pkg::CYC_2MS,
    parameter logic [23:0] SWEEP_TIMEOUT_CYC = 24'hFFFFFF,
    parameter logic [23:0] SETTLE_CYC        = swipt_pkg::CYC_2MS,
    parameter logic [15:0] MEAS_CYC          = 16'h1000,
    parameter logic [23:0] HOLDOFF_CYC       = swipt_pkg::CYC_2MS,
    parameter int          DROP_SHIFT        = 2,
    parameter int          MAX_RETRIES       = 3,
    parameter logic [19:0] DEFAULT_FREQ      = swipt_pkg::DEFAULT_FREQ
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swipt_alive,
    input  logic        enable,
    input  logic [11:0] adc,
    input  logic        adc_valid,
    input  logic        sweep_done,
    input  logic [19:0] sweep_best_freq,
    output logic        sweep_go,
    output logic [19:0] freq_out,
    output logic [10:0] ref_amp,
    output logic        locked,
    output logic        fault,
    output logic [7:0]  resweep_cnt,
    output logic [2:0]  state
);

    import swipt_pkg::*;

    localparam logic [7:0] MAX_RETRY_L = 8'(MAX_RETRIES);

    swipt_state_e state_q, state_d;
    logic [23:0]  cnt_q, cnt_d;
    logic [7:0]   retry_q, retry_d;
    logic [7:0]   retry_inc;
    logic         sweep_go_q, sweep_go_d;
    logic [19:0]  freq_q, freq_d;
    logic [10:0]  ref_amp_q, ref_amp_d;
    logic         locked_q, locked_d;
    logic         fault_q, fault_d;
    logic [7:0]   resweep_q, resweep_d;

    logic         abort;
    logic         peak_clr;
    logic         peak_en;
    logic [10:0]  amp;
    logic [10:0]  peak;
    logic         meas_done;
    logic [10:0]  drop_thresh;

    swipt_amp_peak #(
        .MEAS_CYC (MEAS_CYC)
    ) u_amp_peak (
        .clk       (clk),
        .rst_n     (nrst),
        .clr       (peak_clr),
        .en        (peak_en),
        .adc       (adc),
        .adc_valid (adc_valid),
        .amp       (amp),
        .peak      (peak),
        .done      (meas_done)
    );

    // Shifting right can never exceed ref_amp, so this subtraction cannot wrap.
    assign drop_thresh = ref_amp_q - (ref_amp_q >> DROP_SHIFT);
    assign abort       = !swipt_alive || !enable;

    // Next-state and output logic; link/enable loss overrides everything but FAULT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        sweep_go_d = sweep_go_q;
        freq_d     = freq_q;
        ref_amp_d  = ref_amp_q;
        locked_d   = locked_q;
        fault_d    = fault_q;
        resweep_d  = resweep_q;
        peak_clr   = 1'b0;
        peak_en    = 1'b0;
        retry_inc  = retry_q + 8'd1;

        if (abort && (state_q != ST_FAULT)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            retry_d    = '0;
            sweep_go_d = 1'b0;
            locked_d   = 1'b0;
            freq_d     = DEFAULT_FREQ;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = STARTUP_CYC;
                    state_d = ST_STARTUP;
                end
                ST_STARTUP: begin
                    if (cnt_q == '0) begin
                        cnt_d      = SWEEP_TIMEOUT_CYC;
                        sweep_go_d = 1'b1;
                        state_d    = ST_SWEEP;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
                ST_SWEEP: begin
                    if (sweep_done) begin
                        freq_d     = sweep_best_freq;
                        sweep_go_d = 1'b0;
                        retry_d    = '0;
                        cnt_d      = SETTLE_CYC;
                        state_d    = ST_SETTLE;
                    end else if (cnt_q == '0) begin
                        retry_d    = retry_inc;
                        sweep_go_d = 1'b0;
                        if (retry_inc >= MAX_RETRY_L) begin
                            fault_d = 1'b1;
                            freq_d  = DEFAULT_FREQ;
                            state_d = ST_FAULT;
                        end else begin
                            cnt_d = SWEEP_TIMEOUT_CYC;
                        end
                    end else begin
                        cnt_d      = cnt_q - 24'd1;
                        sweep_go_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        peak_clr = 1'b1;
                        state_d  = ST_MEASURE;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
                ST_MEASURE: begin
                    peak_en = 1'b1;
                    if (meas_done) begin
                        ref_amp_d = peak;
                        cnt_d     = HOLDOFF_CYC;
                        locked_d  = 1'b1;
                        state_d   = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else if (adc_valid && (amp < drop_thresh)) begin
                        locked_d   = 1'b0;
                        sweep_go_d = 1'b1;
                        cnt_d      = SWEEP_TIMEOUT_CYC;
                        state_d    = ST_SWEEP;
                        if (resweep_q != 8'hFF) begin
                            resweep_d = resweep_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    fault_d    = 1'b1;
                    sweep_go_d = 1'b0;
                    freq_d     = DEFAULT_FREQ;
                    if (!enable) begin
                        fault_d = 1'b0;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    sweep_go_d = 1'b0;
                    locked_d   = 1'b0;
                    freq_d     = DEFAULT_FREQ;
                end
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            sweep_go_q <= 1'b0;
            freq_q     <= DEFAULT_FREQ;
            ref_amp_q  <= '0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
            resweep_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            sweep_go_q <= sweep_go_d;
            freq_q     <= freq_d;
            ref_amp_q  <= ref_amp_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
            resweep_q  <= resweep_d;
        end
    end

    assign sweep_go    = sweep_go_q;
    assign freq_out    = freq_q;
    assign ref_amp     = ref_amp_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign resweep_cnt = resweep_q;
    assign state       = state_q;

endmodule

// File: tb/tb_swipt_freq_sequencer.sv
// Testbench for swipt_freq_sequencer with shortened timing parameters.
// Lock results are pushed to a scoreboard when a lock is requested and
// popped when the DUT raises locked.
module tb_swipt_freq_sequencer;

    localparam logic [23:0] STARTUP_CYC = 24'd10;
    localparam logic [23:0] TIMEOUT_CYC = 24'd20;
    localparam logic [23:0] SETTLE_CYC  = 24'd5;
    localparam logic [15:0] MEAS_CYC    = 16'd4;
    localparam logic [23:0] HOLDOFF_CYC = 24'd8;
    localparam int          MAX_RETRIES = 3;
    localparam logic [19:0] DEF_FREQ    = 20'h88B8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SWEEP   = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_MEASURE = 3'd4;
    localparam logic [2:0] S_TRACK   = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        swipt_alive = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] adc = 12'h800;
    logic        adc_valid = 1'b0;
    logic        sweep_done = 1'b0;
    logic [19:0] sweep_best_freq = '0;
    logic        sweep_go;
    logic [19:0] freq_out;
    logic [10:0] ref_amp;
    logic        locked;
    logic        fault;
    logic [7:0]  resweep_cnt;
    logic [2:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [11:0] adc;
        logic [19:0] best;
        logic [10:0] exp_ref;
    } vec_t;

    typedef struct {
        logic [10:0] ref_amp;
        logic [19:0] freq;
    } lock_exp_t;

    vec_t      vecs[6];
    lock_exp_t exp_q[$];

    swipt_freq_sequencer #(
        .STARTUP_CYC       (STARTUP_CYC),
        .SWEEP_TIMEOUT_CYC (TIMEOUT_CYC),
        .SETTLE_CYC        (SETTLE_CYC),
        .MEAS_CYC          (MEAS_CYC),
        .HOLDOFF_CYC       (HOLDOFF_CYC),
        .DROP_SHIFT        (2),
        .MAX_RETRIES       (MAX_RETRIES),
        .DEFAULT_FREQ      (DEF_FREQ)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .swipt_alive     (swipt_alive),
        .enable          (enable),
        .adc             (adc),
        .adc_valid       (adc_valid),
        .sweep_done      (sweep_done),
        .sweep_best_freq (sweep_best_freq),
        .sweep_go        (sweep_go),
        .freq_out        (freq_out),
        .ref_amp         (ref_amp),
        .locked          (locked),
        .fault           (fault),
        .resweep_cnt     (resweep_cnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitState(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, state, target);
    endtask

    task automatic pushLock(input logic [10:0] r, input logic [19:0] f);
        lock_exp_t e;
        e.ref_amp = r;
        e.freq    = f;
        exp_q.push_back(e);
    endtask

    // Full lock from IDLE: startup latency, freq latch on done, lock via scoreboard.
    task automatic applyStimulus(input vec_t v, input bit keep_running);
        int n;
        adc         = v.adc;
        adc_valid   = 1'b1;
        swipt_alive = 1'b1;
        enable      = 1'b1;
        pushLock(v.exp_ref, v.best);
        n = 0;
        while (sweep_go !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        // IDLE sees enable at the next edge; go follows STARTUP_CYC+1 edges later.
        checkOutput("startup latency", n, 32'(STARTUP_CYC) + 2);
        tick(3);
        checkOutput("freq before done", freq_out, DEF_FREQ);
        sweep_done      = 1'b1;
        sweep_best_freq = v.best;
        tick(1);
        checkOutput("freq after done", freq_out, v.best);
        checkOutput("state after done", state, S_SETTLE);
        sweep_done = 1'b0;
        waitState(S_TRACK, 60, "reach TRACK");
        checkOutput("locked in TRACK", locked, 1);
        if (!keep_running) begin
            enable = 1'b0;
            tick(1);
            checkOutput("disable -> IDLE", state, S_IDLE);
            checkOutput("disable freq", freq_out, DEF_FREQ);
            checkOutput("disable locked", locked, 0);
        end
    endtask

    // Scoreboard consumer: every rising edge of locked must match a queued expectation.
    logic      locked_prev = 1'b0;
    lock_exp_t got_exp;
    always @(negedge clk) begin
        if (locked === 1'b1 && locked_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected lock: got ref_amp %0h, expected no lock", ref_amp);
            end else begin
                got_exp = exp_q.pop_front();
                checkOutput("lock ref_amp", ref_amp, got_exp.ref_amp);
                checkOutput("lock freq_out", freq_out, got_exp.freq);
            end
        end
        locked_prev = locked;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int falls;
        logic prev_go;

        vecs[0] = '{adc: 12'h000, best: 20'h9C40, exp_ref: 11'h7FF};
        vecs[1] = '{adc: 12'h7FF, best: 20'h9000, exp_ref: 11'h000};
        vecs[2] = '{adc: 12'h800, best: 20'h9100, exp_ref: 11'h000};
        vecs[3] = '{adc: 12'hFFF, best: 20'h9200, exp_ref: 11'h7FF};
        vecs[4] = '{adc: 12'h400, best: 20'h9300, exp_ref: 11'h3FF};
        vecs[5] = '{adc: 12'hC00, best: 20'hA000, exp_ref: 11'h400};

        #1 nrst = 1'b0;
        #12;
        checkOutput("reset state", state, S_IDLE);
        checkOutput("reset sweep_go", sweep_go, 0);
        checkOutput("reset freq_out", freq_out, DEF_FREQ);
        checkOutput("reset ref_amp", ref_amp, 0);
        checkOutput("reset locked", locked, 0);
        checkOutput("reset fault", fault, 0);
        checkOutput("reset resweep_cnt", resweep_cnt, 0);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end
        applyStimulus(vecs[5], 1'b1);

        // Drop detection around ref 0x400 (threshold 0x300).
        adc = 12'h900;
        tick(1);
        checkOutput("holdoff ignores drop", state, S_TRACK);
        checkOutput("holdoff resweep_cnt", resweep_cnt, 0);
        adc = 12'hC00;
        tick(10);
        adc = 12'hB01;
        tick(1);
        checkOutput("amp 0x301 no resweep", state, S_TRACK);
        adc = 12'hB00;
        tick(1);
        checkOutput("amp 0x300 no resweep", state, S_TRACK);
        adc = 12'hAFF;
        tick(1);
        checkOutput("amp 0x2FF resweep state", state, S_SWEEP);
        checkOutput("resweep_cnt after drop", resweep_cnt, 1);
        checkOutput("locked after drop", locked, 0);
        checkOutput("sweep_go after drop", sweep_go, 1);
        checkOutput("freq held in SWEEP", freq_out, 20'hA000);
        adc = 12'hC00;

        // One timeout, then sweep_done on the next timeout cycle.
        n = 0;
        while (sweep_go !== 1'b0 && n < 60) begin
            tick(1);
            n++;
        end
        checkOutput("first timeout cycles", n, 32'(TIMEOUT_CYC) + 1);
        tick(1);
        checkOutput("timeout pulse one cycle", sweep_go, 1);
        tick(19);
        sweep_done      = 1'b1;
        sweep_best_freq = 20'hB000;
        pushLock(11'h400, 20'hB000);
        tick(1);
        checkOutput("done beats timeout state", state, S_SETTLE);
        checkOutput("done beats timeout freq", freq_out, 20'hB000);
        checkOutput("done beats timeout go", sweep_go, 0);
        sweep_done = 1'b0;
        waitState(S_TRACK, 60, "relock TRACK");

        // Re-sweep that never completes: retries must start from zero.
        tick(10);
        adc = 12'hAFF;
        tick(1);
        checkOutput("second resweep state", state, S_SWEEP);
        checkOutput("second resweep_cnt", resweep_cnt, 2);
        adc   = 12'hC00;
        falls = 0;
        n     = 0;
        while (fault !== 1'b1 && n < 200) begin
            prev_go = sweep_go;
            tick(1);
            n++;
            if (prev_go === 1'b1 && sweep_go === 1'b0) falls++;
        end
        checkOutput("sweep_go falls before FAULT", falls, MAX_RETRIES);
        checkOutput("fault set", fault, 1);
        checkOutput("FAULT state", state, S_FAULT);
        checkOutput("FAULT freq", freq_out, DEF_FREQ);
        checkOutput("FAULT sweep_go", sweep_go, 0);
        swipt_alive = 1'b0;
        tick(2);
        checkOutput("alive low keeps FAULT", state, S_FAULT);
        swipt_alive = 1'b1;
        enable      = 1'b0;
        tick(1);
        checkOutput("enable low exits FAULT", state, S_IDLE);
        checkOutput("fault cleared", fault, 0);
        checkOutput("resweep_cnt held", resweep_cnt, 2);

        // Abort in SWEEP and in MEASURE.
        adc_valid = 1'b0;
        enable    = 1'b1;
        waitState(S_SWEEP, 40, "reach SWEEP for abort");
        tick(2);
        swipt_alive = 1'b0;
        tick(1);
        checkOutput("abort SWEEP state", state, S_IDLE);
        checkOutput("abort SWEEP go", sweep_go, 0);
        checkOutput("abort SWEEP freq", freq_out, DEF_FREQ);
        checkOutput("abort SWEEP resweep_cnt", resweep_cnt, 2);
        swipt_alive = 1'b1;
        waitState(S_SWEEP, 40, "reach SWEEP again");
        sweep_done      = 1'b1;
        sweep_best_freq = 20'hC000;
        tick(1);
        sweep_done = 1'b0;
        waitState(S_MEASURE, 40, "reach MEASURE for abort");
        tick(3);
        checkOutput("MEASURE waits for valid", state, S_MEASURE);
        checkOutput("MEASURE freq", freq_out, 20'hC000);
        swipt_alive = 1'b0;
        tick(1);
        checkOutput("abort MEASURE state", state, S_IDLE);
        checkOutput("abort MEASURE freq", freq_out, DEF_FREQ);
        checkOutput("abort MEASURE locked", locked, 0);
        checkOutput("abort MEASURE resweep_cnt", resweep_cnt, 2);

        // MEASURE with adc_valid toggling every other cycle.
        adc         = 12'h000;
        swipt_alive = 1'b1;
        pushLock(11'h7FF, 20'hD000);
        waitState(S_SWEEP, 40, "reach SWEEP toggled");
        sweep_done      = 1'b1;
        sweep_best_freq = 20'hD000;
        tick(1);
        sweep_done = 1'b0;
        waitState(S_MEASURE, 40, "reach MEASURE toggled");
        adc_valid = 1'b1;
        n = 0;
        while (state !== S_TRACK && n < 50) begin
            tick(1);
            n++;
            if (state !== S_TRACK) adc_valid = ~adc_valid;
        end
        checkOutput("toggled-valid MEASURE length", n, 2 * 32'(MEAS_CYC));
        adc_valid = 1'b1;
        enable    = 1'b0;
        tick(1);

        // Asynchronous reset in the middle of SETTLE.
        enable = 1'b1;
        waitState(S_SWEEP, 40, "reach SWEEP for reset");
        sweep_done      = 1'b1;
        sweep_best_freq = 20'hE000;
        tick(1);
        sweep_done = 1'b0;
        tick(2);
        checkOutput("mid SETTLE", state, S_SETTLE);
        #2 nrst = 1'b0;
        #1;
        checkOutput("async reset state", state, S_IDLE);
        checkOutput("async reset go", sweep_go, 0);
        checkOutput("async reset freq", freq_out, DEF_FREQ);
        checkOutput("async reset ref_amp", ref_amp, 0);
        checkOutput("async reset locked", locked, 0);
        checkOutput("async reset fault", fault, 0);
        checkOutput("async reset resweep_cnt", resweep_cnt, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick(2);

        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
